cpu_controller: RTL and testbench

//  Fetch/decode/sequencing stage feeding the CPU ALU. Fetches 13-bit instructions, reads operands,

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_pc.sv | 40 ++++
 rtl/cpu_controller.sv | 148 ++++++++++++++
 tb/tb_cpu_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller and the ALU it feeds: opcode
// encodings, instruction field layout and the sequencing FSM states.
// Optional feature: CPU_SKZ_EN enables OP_SKZ decoding in cpu_controller.
package cpu_pkg;

  localparam int unsigned INSTR_W = 13;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned IADDR_W = 8;
  localparam int unsigned OPC_LSB = IADDR_W;

  localparam logic [OPC_W-1:0] OP_HLT = 5'h00;
  localparam logic [OPC_W-1:0] OP_ADD = 5'h01;
  localparam logic [OPC_W-1:0] OP_SUB = 5'h02;
  localparam logic [OPC_W-1:0] OP_AND = 5'h03;
  localparam logic [OPC_W-1:0] OP_OR  = 5'h04;
  localparam logic [OPC_W-1:0] OP_LDA = 5'h05;
  localparam logic [OPC_W-1:0] OP_STO = 5'h06;
  localparam logic [OPC_W-1:0] OP_JMP = 5'h07;
  localparam logic [OPC_W-1:0] OP_XOR = 5'h08;
  localparam logic [OPC_W-1:0] OP_SKZ = 5'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPRD,
    ST_EXEC,
    ST_WB,
    ST_STORE,
    ST_HALT
  } state_e;

endpackage

// File: rtl/cpu_pc.sv
// Program counter register.
//   clk, rst_n  : clock, asynchronous active-low reset (PC -> RESET_PC)
//   load        : load load_val (jump); has priority over inc
//   inc         : increment by one, wrapping modulo 2**PC_W
//   pc          : current program counter
module cpu_pc #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/sequencing stage in front of the CPU ALU. Owns PC, IR and ACC,
// keeps one instruction in flight and talks to instruction and data memory
// through req/ack handshakes (req held until a one-cycle ack).
//   clk, rst_clk          : clock, asynchronous active-low reset
//   run                   : leaves IDLE when high
//   imem_req/addr/ack/rdata : instruction fetch port
//   dmem_req/we/addr/wdata/ack/rdata : data port (read operand, STO write)
//   optcode/alu_data/accmu/ena : ALU drive; alu_out is the registered ALU result
//   halted, pc            : status
// Optional feature: define CPU_SKZ_EN to decode opcode 01001 as SKZ (skip next
// instruction when ACC is zero); otherwise it decodes as a NOP.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_clk,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [PC_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [OPC_W-1:0]   optcode,
  output logic [DATA_W-1:0]  alu_data,
  output logic [DATA_W-1:0]  accmu,
  output logic               ena,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               halted,
  output logic [PC_W-1:0]    pc
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   alu_data_q, alu_data_d;
  logic                pc_load;
  logic                pc_inc;
  logic [PC_W-1:0]     ir_addr;
  logic [OPC_W-1:0]    opcode;

  assign opcode  = ir_q[OPC_LSB +: OPC_W];
  assign ir_addr = PC_W'(ir_q[IADDR_W-1:0]);

  cpu_pc #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_clk),
    .load    (pc_load),
    .load_val(ir_addr),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    alu_data_d = alu_data_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_HLT: state_d = ST_HALT;
          OP_JMP: begin
            pc_load = 1'b1;
            state_d = ST_FETCH;
          end
          OP_STO: state_d = ST_STORE;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDA: state_d = ST_OPRD;
`ifdef CPU_SKZ_EN
          OP_SKZ: begin
            pc_inc  = (acc_q == '0);
            state_d = ST_FETCH;
          end
`endif
          default: state_d = ST_FETCH;
        endcase
      end
      ST_OPRD: begin
        if (dmem_ack) begin
          alu_data_d = dmem_rdata;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WB;
      // ALU result is taken as-is; SUB therefore leaves data-ACC in ACC.
      ST_WB: begin
        acc_d   = alu_out;
        state_d = ST_FETCH;
      end
      ST_STORE: begin
        if (dmem_ack) state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      acc_q      <= '0;
      alu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      alu_data_q <= alu_data_d;
    end
  end

  // Requests are decoded from state alone so reset drops them asynchronously.
  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state_q == ST_OPRD) || (state_q == ST_STORE);
  assign dmem_we    = (state_q == ST_STORE);
  assign dmem_addr  = ir_addr;
  assign dmem_wdata = acc_q;
  assign optcode    = opcode;
  assign alu_data   = alu_data_q;
  assign accmu      = acc_q;
  assign ena        = (state_q == ST_EXEC);
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_clk = 1'b0;
  logic        run = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [7:0]  imem_addr;
  logic [12:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [4:0]  optcode;
  logic [7:0]  alu_data, accmu, alu_out = '0, pc;
  logic        ena, halted;

  always #5 clk = ~clk;

  cpu_controller #(.PC_W(8), .DATA_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_clk(rst_clk), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .optcode(optcode), .alu_data(alu_data), .accmu(accmu), .ena(ena), .alu_out(alu_out),
    .halted(halted), .pc(pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memories seen by the DUT, and the reference model's view of data memory.
  logic [12:0] imem [256];
  logic [7:0]  mem  [256];
  logic [7:0]  m_dmem [256];

  // Instruction-level reference model state.
  logic [7:0] m_pc, m_acc, exp_daddr, exp_opnd, exp_acc_in;
  logic [4:0] cur_op;
  bit         m_halted, have_prev, hold_d;
  int         base_cyc, exp_ena, exp_wr, cyc, waits, ena_cnt, wr_cnt, fetched;
  bit         i_busy, d_busy;
  int         i_wait, d_wait, max_wait;

  function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] d, input logic [7:0] a);
    case (op)
      5'h01: return a + d;
      5'h02: return d - a;
      5'h03: return d & a;
      5'h04: return d | a;
      5'h05: return d;
      5'h08: return d ^ a;
      default: return a;
    endcase
  endfunction

  // Whole-instruction effect, applied when the fetch handshake completes.
  task automatic model_exec();
    logic [12:0] instr;
    logic [4:0]  op;
    logic [7:0]  a;
    if (have_prev) begin
      check("cycles", cyc, base_cyc + waits);
      check("ena_count", ena_cnt, exp_ena);
      check("write_count", wr_cnt, exp_wr);
    end
    check("acc", accmu, m_acc);
    check("not_halted", halted, 0);
    instr = imem[m_pc];
    op = instr[12:8];
    a  = instr[7:0];
    m_pc = m_pc + 8'd1;
    exp_daddr = a; exp_acc_in = m_acc; exp_opnd = m_dmem[a];
    exp_ena = 0; exp_wr = 0; cur_op = op; base_cyc = 2;
    case (op)
      5'h00: m_halted = 1'b1;
      5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h08: begin
        m_acc = alu_f(op, m_dmem[a], m_acc);
        exp_ena = 1; base_cyc = 5;
      end
      5'h06: begin m_dmem[a] = m_acc; exp_wr = 1; base_cyc = 3; end
      5'h07: m_pc = a;
      5'h09: begin
`ifdef CPU_SKZ_EN
        if (m_acc == 8'd0) m_pc = m_pc + 8'd1;
`endif
      end
      default: ;
    endcase
    waits = 0; cyc = 0; ena_cnt = 0; wr_cnt = 0; have_prev = 1'b1; fetched++;
  endtask

  // One clock: observe at negedge, respond, let the edge happen.
  task automatic cycle();
    bit         pend;
    logic [7:0] pval;
    pend = 1'b0; pval = '0;
    cyc++;
    if (m_halted && cyc >= 2) begin
      check("halted", halted, 1);
      check("halt_no_req", {imem_req, dmem_req}, 0);
      run = 1'($urandom);
    end
    if (imem_req) begin
      check("imem_addr", imem_addr, m_pc);
      check("fetch_no_dreq", dmem_req, 0);
      if (!i_busy) begin i_busy = 1'b1; i_wait = $urandom_range(0, max_wait); end
      if (i_wait == 0) begin
        imem_ack = 1'b1; imem_rdata = imem[imem_addr]; i_busy = 1'b0;
        model_exec();
      end else begin
        i_wait--; waits++;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      imem_ack = 1'b1; imem_rdata = 13'($urandom);
    end
    if (dmem_req) begin
      check("dmem_addr", dmem_addr, exp_daddr);
      check("dmem_we", dmem_we, exp_wr);
      if (dmem_we) check("dmem_wdata", dmem_wdata, exp_acc_in);
      if (!d_busy) begin d_busy = 1'b1; d_wait = $urandom_range(0, max_wait); end
      if (d_wait == 0 && !hold_d) begin
        dmem_ack = 1'b1; d_busy = 1'b0;
        if (dmem_we) begin mem[dmem_addr] = dmem_wdata; wr_cnt++; end
        else dmem_rdata = mem[dmem_addr];
      end else begin
        if (d_wait > 0) d_wait--;
        waits++;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      dmem_ack = 1'b1; dmem_rdata = 8'($urandom);
    end
    if (ena) begin
      ena_cnt++;
      check("optcode", optcode, cur_op);
      check("alu_data", alu_data, exp_opnd);
      check("accmu_exec", accmu, exp_acc_in);
      pend = 1'b1; pval = alu_f(optcode, alu_data, accmu);
    end
    @(posedge clk);
    #1;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (pend) alu_out = pval;
    @(negedge clk);
  endtask

  task automatic model_init();
    m_pc = 8'd0; m_acc = 8'd0; m_halted = 1'b0; have_prev = 1'b0;
    i_busy = 1'b0; d_busy = 1'b0; fetched = 0; cyc = 0; waits = 0;
    for (int i = 0; i < 256; i++) m_dmem[i] = mem[i];
  endtask

  task automatic run_prog(input int n, input int budget);
    bit done;
    done = 1'b0;
    model_init();
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (fetched >= n || (m_halted && cyc >= 12)) begin done = 1'b1; break; end
    end
    check("run_timeout", done, 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_ctl"}, {imem_req, dmem_req, dmem_we, ena, halted}, 0);
    check({tag, "_regs"}, {optcode, alu_data, accmu}, 0);
    check({tag, "_addr"}, {imem_addr, dmem_addr, dmem_wdata}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_clk = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_out = '0;
    #1 reset_checks("rst");
    @(negedge clk);
    rst_clk = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_req", {imem_req, dmem_req}, 0);
    end
    run = 1'b1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 13'h1F00;
      mem[i]  = 8'($urandom);
    end
  endtask

  initial begin
    hold_d = 1'b0; max_wait = 3;

    // Directed: LDA/ADD/STO, unknown opcode, 01001, JMP to 0xFE, wrap to 0x00.
    fill_nop();
    mem[8'h10] = 8'h05; mem[8'h11] = 8'h03;
    imem[0] = 13'h0510; imem[1] = 13'h0111; imem[2] = 13'h0620;
    imem[3] = 13'h1F00; imem[4] = 13'h0900; imem[5] = 13'h07FE;
    imem[8'hFE] = 13'h0111; imem[8'hFF] = 13'h1F00;
    do_reset();
    run_prog(12, 400);
    check("sto_mem", mem[8'h20], 8'h08);
    check("pc_after_wrap", pc, 8'h04);

    // Skip-if-zero with ACC==0 and ACC==1.
    for (int v = 0; v < 2; v++) begin
      fill_nop();
      mem[8'h12] = 8'(v);
      imem[0] = 13'h0512; imem[4] = 13'h0900;
      do_reset();
      run_prog(7, 300);
`ifdef CPU_SKZ_EN
      check("skz_pc", pc, (v == 0) ? 8'h08 : 8'h07);
`else
      check("skz_pc", pc, 8'h07);
`endif
    end

    // Reset while the operand read is outstanding; the late ack must be ignored.
    fill_nop();
    imem[0] = 13'h0510; mem[8'h10] = 8'h5A;
    do_reset();
    model_init();
    hold_d = 1'b1;
    for (int c = 0; c < 30 && !dmem_req; c++) cycle();
    check("oprd_reached", dmem_req, 1);
    #2 rst_clk = 1'b0;
    #1 reset_checks("async_rst");
    hold_d = 1'b0; run = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 8'hAA;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    rst_clk = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {imem_req, dmem_req, alu_data}, 0);
    end
    run = 1'b1;
    run_prog(3, 200);

    // Directed halt, then run toggling while halted.
    fill_nop();
    imem[0] = 13'h0510; imem[1] = 13'h1F00; imem[2] = 13'h0000;
    do_reset();
    run_prog(100, 400);
    check("halt_reached", halted, 1);

    // Randomised programs.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) begin
        int r;
        logic [4:0] op;
        r = $urandom_range(0, 99);
        if (r < 2) op = 5'h00;
        else if (r < 90) op = 5'($urandom_range(1, 9));
        else op = 5'($urandom_range(10, 31));
        imem[i] = {op, 8'($urandom)};
        mem[i]  = 8'($urandom);
      end
      max_wait = t % 4;
      do_reset();
      run_prog(40, 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
